// File: rtl/stereo_proc_param_if.sv
// Sample/handshake bundle for the joint-stereo stage. The driving side
// (requantiser upstream plus the consumer downstream) uses "master"; the
// stereo stage itself uses "slave".
interface stereo_proc_param_if #(
   parameter int WIDTH = 32
);
   logic [1:0]              mode_in;
   logic [1:0]              mode_ext_in;
   logic [9:0]              is_bound_in;
   logic                    gr_in;
   logic signed [WIDTH-1:0] ch1_in;
   logic signed [WIDTH-1:0] ch2_in;
   logic [2:0]              is_pos_in;
   logic                    din_v;
   logic                    din_rdy;
   logic signed [WIDTH-1:0] ch1_out;
   logic signed [WIDTH-1:0] ch2_out;
   logic [9:0]              line_out;
   logic                    last_out;
   logic                    gr_out;
   logic                    dout_v;
   logic                    dout_rdy;

   modport master (
      output mode_in, mode_ext_in, is_bound_in, gr_in, ch1_in, ch2_in,
             is_pos_in, din_v, dout_rdy,
      input  din_rdy, ch1_out, ch2_out, line_out, last_out, gr_out, dout_v
   );

   modport slave (
      input  mode_in, mode_ext_in, is_bound_in, gr_in, ch1_in, ch2_in,
             is_pos_in, din_v, dout_rdy,
      output din_rdy, ch1_out, ch2_out, line_out, last_out, gr_out, dout_v
   );
endinterface

// File: rtl/stereo_proc_param.sv
// Joint-stereo reconstruction (mid/side and intensity) for one granule of
// N_LINES lines per channel. Two stages: S1 forms sum/difference and
// multiplies by a Q1.COEF_FRAC coefficient, S2 rounds and saturates.
// Config is captured with line 0 and held for the whole granule.
module stereo_proc_param #(
   parameter int WIDTH     = 32,
   parameter int COEF_FRAC = 15,
   parameter int N_LINES   = 576
) (
   input logic                clk,
   input logic                rst,
   stereo_proc_param_if.slave bus
);

   localparam int KW = COEF_FRAC + 2;  // coefficient, signed, holds +1.0
   localparam int AW = WIDTH + 1;      // sum/difference never overflows
   localparam int PW = AW + KW;        // full product
   localparam int LW = 10;

   function automatic logic signed [KW-1:0] to_coef(input real f);
      return KW'($rtoi(f * real'(longint'(1) << COEF_FRAC) + 0.5));
   endfunction

   // Passthrough is a multiply by exactly 1.0 so all modes share one path.
   localparam logic signed [KW-1:0] K_ONE = to_coef(1.0);
   localparam logic signed [KW-1:0] K_MS  = to_coef(0.7071067811865476);
   // Intensity ratios r/(1+r) with r = tan(p*pi/12); kr[p] = kl[6-p].
   localparam logic signed [KW-1:0] K_IS1 = to_coef(0.2113248654051871);
   localparam logic signed [KW-1:0] K_IS2 = to_coef(0.3660254037844386);
   localparam logic signed [KW-1:0] K_IS3 = to_coef(0.5);
   localparam logic signed [KW-1:0] K_IS4 = to_coef(0.6339745962155614);
   localparam logic signed [KW-1:0] K_IS5 = to_coef(0.7886751345948129);

   localparam logic signed [PW-1:0] RND    = PW'(1) <<< (COEF_FRAC - 1);
   localparam logic signed [PW-1:0] SAT_HI = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
   localparam logic signed [PW-1:0] SAT_LO = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {SEL_PASS, SEL_MS, SEL_IS} sel_t;

   logic [LW-1:0]         line_cnt;
   logic [1:0]            mode_q, ext_q;
   logic [LW-1:0]         bound_q;
   logic                  gr_q;
   logic                  stall, accept, first_line;
   logic [1:0]            cur_mode, cur_ext;
   logic [LW-1:0]         cur_bound;
   logic                  cur_gr;
   sel_t                  sel;
   logic signed [AW-1:0]  a_l, a_r;
   logic signed [KW-1:0]  k_l, k_r;
   logic                  s1_v;
   logic signed [PW-1:0]  p_l, p_r;
   logic [LW-1:0]         s1_line;
   logic                  s1_last, s1_gr;

   function automatic logic signed [WIDTH-1:0] round_sat(input logic signed [PW-1:0] p);
      logic signed [PW-1:0] t;
      t = (p + RND) >>> COEF_FRAC;
      if (t > SAT_HI) return SAT_HI[WIDTH-1:0];
      if (t < SAT_LO) return SAT_LO[WIDTH-1:0];
      return t[WIDTH-1:0];
   endfunction

   // A full output that is not being taken freezes the whole pipe.
   assign stall       = bus.dout_v && !bus.dout_rdy;
   assign bus.din_rdy = !stall;
   assign accept      = bus.din_v && !stall;
   assign first_line  = (line_cnt == '0);

   // Line 0 uses the live config; the rest of the granule uses the copy.
   assign cur_mode  = first_line ? bus.mode_in     : mode_q;
   assign cur_ext   = first_line ? bus.mode_ext_in : ext_q;
   assign cur_bound = first_line ? bus.is_bound_in : bound_q;
   assign cur_gr    = first_line ? bus.gr_in       : gr_q;

   // Choose the reconstruction for this line and set up multiplier operands.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
      sel = SEL_PASS;
      a_l = AW'(bus.ch1_in);
      a_r = AW'(bus.ch2_in);
      k_l = K_ONE;
      k_r = K_ONE;
      if (cur_mode == 2'b01 && cur_ext[0] && line_cnt >= cur_bound && bus.is_pos_in != 3'd7)
         sel = SEL_IS;
      else if (cur_mode == 2'b01 && cur_ext[1])
         sel = SEL_MS;
      case (sel)
         SEL_MS: begin
            a_l = AW'(bus.ch1_in) + AW'(bus.ch2_in);
            a_r = AW'(bus.ch1_in) - AW'(bus.ch2_in);
            k_l = K_MS;
            k_r = K_MS;
         end
         SEL_IS: begin
            a_r = AW'(bus.ch1_in);
            case (bus.is_pos_in)
               3'd0:    begin k_l = '0;    k_r = K_ONE; end
               3'd1:    begin k_l = K_IS1; k_r = K_IS5; end
               3'd2:    begin k_l = K_IS2; k_r = K_IS4; end
               3'd3:    begin k_l = K_IS3; k_r = K_IS3; end
               3'd4:    begin k_l = K_IS4; k_r = K_IS2; end
               3'd5:    begin k_l = K_IS5; k_r = K_IS1; end
               default: begin k_l = K_ONE; k_r = '0;    end
            endcase
         end
         default: ;
      endcase
   end

   // Line counter and per-granule config, captured with line 0.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
      if (rst) begin
         line_cnt <= '0;
         mode_q   <= '0;
         ext_q    <= '0;
         bound_q  <= '0;
         gr_q     <= 1'b0;
      end else if (accept) begin
         if (first_line) begin
            mode_q  <= bus.mode_in;
            ext_q   <= bus.mode_ext_in;
            bound_q <= bus.is_bound_in;
            gr_q    <= bus.gr_in;
         end
         line_cnt <= (line_cnt == LW'(N_LINES - 1)) ? '0 : line_cnt + LW'(1);
      end
   end

   // S1 occupancy flag.
   always_ff @(posedge clk) begin
      if (rst)         s1_v <= 1'b0;
      else if (!stall) s1_v <= accept;
   end

   // S1 products and sideband for the sample entering the pipe.
   always_ff @(posedge clk) begin
      // NOTE: payload registers carry no reset; s1_v alone says whether they mean anything.
      if (!stall && accept) begin
         p_l     <= PW'(a_l) * PW'(k_l);
         p_r     <= PW'(a_r) * PW'(k_r);
         s1_line <= line_cnt;
         s1_last <= (line_cnt == LW'(N_LINES - 1));
         s1_gr   <= cur_gr;
      end
   end

   // S2: round, saturate and present the sample with its line tag.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.dout_v   <= 1'b0;
         bus.ch1_out  <= '0;
         bus.ch2_out  <= '0;
         bus.line_out <= '0;
         bus.last_out <= 1'b0;
         bus.gr_out   <= 1'b0;
      end else if (!stall) begin
         bus.dout_v <= s1_v;
         if (s1_v) begin
            bus.ch1_out  <= round_sat(p_l);
            bus.ch2_out  <= round_sat(p_r);
            bus.line_out <= s1_line;
            bus.last_out <= s1_last;
            bus.gr_out   <= s1_gr;
         end
      end
   end

endmodule
